// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and loader state encoding
package program_loader_pkg;

  localparam int         PL_BYTE_WIDTH  = 8;
  localparam int         PL_INST_WIDTH  = 32;
  localparam logic [5:0] PL_HALT_OPCODE = 6'b111111;

  // Encoding is fixed so the debug unit can decode the raw state bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// rtl/program_loader_byte_packer.sv - big-endian byte to word assembler with word_valid pulse
module program_loader_byte_packer
  import program_loader_pkg::*;
#(
  parameter int BYTE_WIDTH = PL_BYTE_WIDTH,
  parameter int INST_WIDTH = PL_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [INST_WIDTH-1:0] word,
  output logic                  word_valid
);

  logic [1:0]                       byte_idx;
  logic [INST_WIDTH-BYTE_WIDTH-1:0] asm_reg;
  logic [INST_WIDTH-1:0]            shifted;

  assign shifted = {asm_reg, byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      asm_reg    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
        asm_reg  <= '0;
      end else if (byte_valid) begin
        asm_reg  <= shifted[INST_WIDTH-BYTE_WIDTH-1:0];
        byte_idx <= byte_idx + 2'd1;
        // Word is frozen here so a byte arriving during the write cycle cannot disturb it.
        if (byte_idx == 2'd3) begin
          word       <= shifted;
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART byte stream to instruction memory loader; optional PROGRAM_LOADER_CHECKSUM_EN
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         BYTE_WIDTH  = PL_BYTE_WIDTH,
  parameter int         INST_WIDTH  = PL_INST_WIDTH,
  parameter int         ADDR_WIDTH  = 10,
  parameter logic [5:0] HALT_OPCODE = PL_HALT_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic [BYTE_WIDTH-1:0] checksum,
  output logic                  checksum_err
`endif
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_t HALT_NEXT = ST_CHK;
  logic [BYTE_WIDTH-1:0] checksum_n;
  logic                  checksum_err_n;
`else
  localparam loader_state_t HALT_NEXT = ST_DONE;
`endif

  loader_state_t         state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH:0]   count_n;
  logic                  overflow_n;
  logic                  pack_valid;
  logic                  is_halt;
  logic                  at_last;

  program_loader_byte_packer #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  assign is_halt   = (imem_wdata[INST_WIDTH-1 -: 6] == HALT_OPCODE);
  assign at_last   = (addr == '1);
  assign imem_addr = addr;
  assign busy      = (state == ST_RECV);
  assign load_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr         <= '0;
      word_count   <= '0;
      overflow     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum     <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      word_count   <= count_n;
      overflow     <= overflow_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum     <= checksum_n;
      checksum_err <= checksum_err_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    addr_n         = addr;
    count_n        = word_count;
    overflow_n     = overflow;
    pack_valid     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checksum_n     = checksum;
    checksum_err_n = checksum_err;
`endif
    if (start) begin
      state_n        = ST_RECV;
      addr_n         = '0;
      count_n        = '0;
      overflow_n     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum_n     = '0;
      checksum_err_n = 1'b0;
`endif
    end else begin
      case (state)
        ST_RECV: begin
          pack_valid = rx_done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (rx_done) checksum_n = checksum ^ rx_data;
`endif
          if (imem_we) begin
            count_n = word_count + (ADDR_WIDTH+1)'(1);
            // The address saturates at the top word; the full condition ends the load instead.
            if (!at_last) addr_n = addr + ADDR_WIDTH'(1);
            if (is_halt) begin
              state_n = HALT_NEXT;
            end else if (at_last) begin
              state_n    = ST_DONE;
              overflow_n = 1'b1;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (rx_done) begin
            checksum_err_n = (rx_data != checksum);
            checksum_n     = checksum ^ rx_data;
            state_n        = ST_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader (default and 2-bit address instances)
module tb_program_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_s;
  logic [7:0]  rx_data;
  logic        rx_done, rx_done_s;

  logic        imem_we, imem_we_s;
  logic [9:0]  imem_addr;
  logic [1:0]  imem_addr_s;
  logic [31:0] imem_wdata, imem_wdata_s;
  logic        busy, busy_s, load_done, load_done_s, overflow, overflow_s;
  logic [10:0] word_count;
  logic [2:0]  word_count_s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum, checksum_s;
  logic        checksum_err, checksum_err_s;
`endif

  int   checks = 0;
  int   passes = 0;
  wr_t  exp_q[$];
  wr_t  exp_qs[$];
  wr_t  e_m, e_s;
  logic [7:0] run_xor;

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .load_done(load_done), .overflow(overflow), .word_count(word_count)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , .checksum(checksum), .checksum_err(checksum_err)
`endif
  );

  program_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .rx_data(rx_data), .rx_done(rx_done_s),
    .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
    .busy(busy_s), .load_done(load_done_s), .overflow(overflow_s), .word_count(word_count_s)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , .checksum(checksum_s), .checksum_err(checksum_err_s)
`endif
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected addr=%0d data=%h required=no write", imem_addr, imem_wdata);
      end else begin
        e_m = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== {e_m.addr, e_m.data})
          $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                   imem_addr, imem_wdata, e_m.addr, e_m.data);
        else passes++;
      end
    end
  end

  always @(negedge clk) begin
    if (imem_we_s === 1'b1) begin
      checks++;
      if (exp_qs.size() == 0) begin
        $display("FAIL write_s_unexpected addr=%0d data=%h required=no write", imem_addr_s, imem_wdata_s);
      end else begin
        e_s = exp_qs.pop_front();
        if ({8'd0, imem_addr_s, imem_wdata_s} !== {e_s.addr, e_s.data})
          $display("FAIL write_s addr=%0d data=%h required addr=%0d data=%h",
                   imem_addr_s, imem_wdata_s, e_s.addr, e_s.data);
        else passes++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit sm);
    rx_data = b;
    if (sm) rx_done_s = 1'b1;
    else begin
      rx_done = 1'b1;
      run_xor = run_xor ^ b;
    end
    @(negedge clk);
    rx_done   = 1'b0;
    rx_done_s = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input bit wr, input bit sm);
    wr_t e;
    e.addr = 10'(addr);
    e.data = w;
    if (wr) begin
      if (sm) exp_qs.push_back(e);
      else exp_q.push_back(e);
    end
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], sm);
  endtask

  task automatic pulse_start(input bit sm);
    if (sm) start_s = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    start_s = 1'b0;
    run_xor = 8'h00;
  endtask

  task automatic send_chk();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    @(negedge clk);
    c = run_xor;
    send_byte(c, 1'b0);
`endif
  endtask

  task automatic test_reset();
    checks++;
    if ({imem_we, imem_addr, imem_wdata, busy, load_done, overflow, word_count} !== '0)
      $display("FAIL reset_main we=%b addr=%0d data=%h busy=%b done=%b ovf=%b cnt=%0d required all 0",
               imem_we, imem_addr, imem_wdata, busy, load_done, overflow, word_count);
    else passes++;
    checks++;
    if ({imem_we_s, imem_addr_s, imem_wdata_s, busy_s, load_done_s, overflow_s, word_count_s} !== '0)
      $display("FAIL reset_small got=%h required=0",
               {imem_we_s, imem_addr_s, imem_wdata_s, busy_s, load_done_s, overflow_s, word_count_s});
    else passes++;
  endtask

  task automatic test_basic_load();
    pulse_start(1'b0);
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) $display("FAIL basic_busy busy=%b done=%b required busy=1 done=0", busy, load_done);
    else passes++;
    send_word(32'h20010005, 0, 1'b1, 1'b0);
    send_word(32'h00000000, 1, 1'b1, 1'b0);
    send_word(32'hFC000000, 2, 1'b1, 1'b0);
    send_chk();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL basic_pending size=%0d required=0", exp_q.size());
    else passes++;
    checks++;
    if ({load_done, busy, overflow, word_count} !== {1'b1, 1'b0, 1'b0, 11'd3})
      $display("FAIL basic_done done=%b busy=%b ovf=%b cnt=%0d required done=1 busy=0 ovf=0 cnt=3",
               load_done, busy, overflow, word_count);
    else passes++;
    send_word(32'h12345678, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (word_count !== 11'd3 || load_done !== 1'b1)
      $display("FAIL done_ignores_rx cnt=%0d done=%b required cnt=3 done=1", word_count, load_done);
    else passes++;
  endtask

  task automatic test_back_to_back();
    pulse_start(1'b0);
    send_word(32'h11223344, 0, 1'b1, 1'b0);
    send_word(32'h55667788, 1, 1'b1, 1'b0);
    send_word(32'hFC000001, 2, 1'b1, 1'b0);
    send_chk();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || word_count !== 11'd3 || load_done !== 1'b1)
      $display("FAIL b2b_end pending=%0d cnt=%0d done=%b required 0/3/1", exp_q.size(), word_count, load_done);
    else passes++;
  endtask

  task automatic test_restart_partial();
    pulse_start(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    start = 1'b1;
    rx_data = 8'h99;
    rx_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx_done = 1'b0;
    run_xor = 8'h00;
    send_word(32'hAABBCCDD, 0, 1'b1, 1'b0);
    send_word(32'hFC000000, 1, 1'b1, 1'b0);
    send_chk();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || word_count !== 11'd2)
      $display("FAIL restart_end pending=%0d cnt=%0d required 0/2", exp_q.size(), word_count);
    else passes++;
  endtask

  task automatic test_overflow();
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) send_word(32'h01000000 + i, i, 1'b1, 1'b1);
    send_word(32'h05050505, 4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_qs.size() != 0) $display("FAIL ovf_pending size=%0d required=0", exp_qs.size());
    else passes++;
    checks++;
    if ({overflow_s, load_done_s, busy_s, word_count_s} !== {1'b1, 1'b1, 1'b0, 3'd4})
      $display("FAIL ovf_flags ovf=%b done=%b busy=%b cnt=%0d required 1/1/0/4",
               overflow_s, load_done_s, busy_s, word_count_s);
    else passes++;
    pulse_start(1'b1);
    checks++;
    if ({overflow_s, busy_s, word_count_s} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL ovf_clear ovf=%b busy=%b cnt=%0d required 0/1/0", overflow_s, busy_s, word_count_s);
    else passes++;
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0);
    send_word(32'hA1B2C3D4, 0, 1'b1, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    checks++;
    if (busy !== 1'b1 || word_count !== 11'd1)
      $display("FAIL pre_reset busy=%b cnt=%0d required 1/1", busy, word_count);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, busy, load_done, overflow, word_count} !== '0)
      $display("FAIL async_reset addr=%0d data=%h busy=%b cnt=%0d required all 0",
               imem_addr, imem_wdata, busy, word_count);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h01020304, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || word_count !== 11'd0)
      $display("FAIL idle_ignores_rx busy=%b cnt=%0d required 0/0", busy, word_count);
    else passes++;
    pulse_start(1'b0);
    send_word(32'hFC000000, 0, 1'b1, 1'b0);
    send_chk();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || load_done !== 1'b1)
      $display("FAIL post_reset_load pending=%0d done=%b required 0/1", exp_q.size(), load_done);
    else passes++;
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(1'b0);
    send_word(32'hFC000000, 0, 1'b1, 1'b0);
    @(negedge clk);
    send_byte(8'hFC, 1'b0);
    @(negedge clk);
    checks++;
    if (checksum_err !== 1'b0 || load_done !== 1'b1)
      $display("FAIL chk_good err=%b done=%b required 0/1", checksum_err, load_done);
    else passes++;
    pulse_start(1'b0);
    send_word(32'hFC000000, 0, 1'b1, 1'b0);
    @(negedge clk);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (checksum_err !== 1'b1 || load_done !== 1'b1)
      $display("FAIL chk_bad err=%b done=%b required 1/1", checksum_err, load_done);
    else passes++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_done_s = 1'b0;
    run_xor = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic_load();
    test_back_to_back();
    test_restart_partial();
    test_overflow();
    test_async_reset();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
